cbus_rr_arbiter: RTL and testbench

Round-robin arbiter that shares one cache-bus (CBus) port to memory between `NUM_REQ` burst-capable requesters, e.g. the I-cache and D-cache refill engines. It latches a winner, forwards that requester's request fields unchanged downstream, and routes the response handshake back until the last beat completes. It also counts beats and flags downstream responses whose burst length disagrees with the request. It sits between the cache refill units and the top-level CBus-to-AXI bridge.

---
 rtl/cbus_rr_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_cbus_rr_arbiter.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cbus_rr_arbiter.sv
// cbus_rr_arbiter: round-robin owner of one CBus memory port shared by
// NUM_REQ burst requesters. A winner is latched for a whole burst, its request
// fields are forwarded unchanged, the response handshake is routed back to it,
// and a sticky flag records bursts whose beat count disagrees with the length.
module cbus_rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int LEN_W   = 4,
  localparam int GW     = $clog2(NUM_REQ)
) (
  input  logic                            clk,
  input  logic                            resetn,
  input  logic [NUM_REQ-1:0]              ireq_valid,
  input  logic [NUM_REQ-1:0]              ireq_is_write,
  input  logic [NUM_REQ-1:0][31:0]        ireq_addr,
  input  logic [NUM_REQ-1:0][LEN_W-1:0]   ireq_len,
  input  logic [NUM_REQ-1:0][3:0]         ireq_strobe,
  input  logic [NUM_REQ-1:0][31:0]        ireq_data,
  output logic [NUM_REQ-1:0]              iresp_ready,
  output logic [NUM_REQ-1:0]              iresp_last,
  output logic [31:0]                     iresp_data,
  output logic                            oreq_valid,
  output logic                            oreq_is_write,
  output logic [31:0]                     oreq_addr,
  output logic [LEN_W-1:0]                oreq_len,
  output logic [3:0]                      oreq_strobe,
  output logic [31:0]                     oreq_data,
  input  logic                            oresp_ready,
  input  logic                            oresp_last,
  input  logic [31:0]                     oresp_data,
  output logic [GW-1:0]                   grant_idx,
  output logic                            busy,
  output logic                            len_err
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [GW-1:0]     grant_q, grant_d;
  logic [GW-1:0]     last_grant_q, last_grant_d;
  logic [LEN_W-1:0]  beat_cnt_q, beat_cnt_d;
  logic              len_err_q, len_err_d;

  logic              pick_vld_s;
  logic [GW-1:0]     pick_idx_s;
  logic [GW-1:0]     scan_idx_s;
  int                scan_int_s;
  logic              cur_valid_s;
  logic              beat_s;
  logic              done_s;

  // Round-robin scan: walk downward in priority so the last hit is the first
  // asserted requester after last_grant (wrapping modulo NUM_REQ).
  always_comb begin
    pick_vld_s = 1'b0;
    pick_idx_s = '0;
    scan_int_s = 0;
    scan_idx_s = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      scan_int_s = (int'(last_grant_q) + k) % NUM_REQ;
      scan_idx_s = GW'(scan_int_s);
      pick_idx_s = ireq_valid[scan_idx_s] ? scan_idx_s : pick_idx_s;
      pick_vld_s = pick_vld_s | ireq_valid[scan_idx_s];
    end
  end

  assign cur_valid_s = ireq_valid[grant_q];
  assign beat_s      = (state_q == ST_BUSY) & oresp_ready & cur_valid_s;
  assign done_s      = (state_q == ST_BUSY) & oresp_ready & oresp_last;

  // State register: reset aborts any burst in flight.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: grant on any request in IDLE, release on the last beat.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_vld_s) begin
          state_d = ST_BUSY;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (done_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_BUSY;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Bookkeeping next values: winner, round-robin pointer, beat count, error.
  always_comb begin
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    beat_cnt_d   = beat_cnt_q;
    len_err_d    = len_err_q;
    if (state_q == ST_IDLE) begin
      if (pick_vld_s) begin
        grant_d    = pick_idx_s;
        beat_cnt_d = {LEN_W{1'b0}};
      end else begin
        grant_d    = grant_q;
      end
    end else begin
      if (beat_s) begin
        beat_cnt_d = beat_cnt_q + {{(LEN_W-1){1'b0}}, 1'b1};
      end else begin
        beat_cnt_d = beat_cnt_q;
      end
      if (done_s) begin
        last_grant_d = grant_q;
        // Compare the count of beats before this one against len (beats-1).
        if (beat_cnt_q != ireq_len[grant_q]) begin
          len_err_d = 1'b1;
        end else begin
          len_err_d = len_err_q;
        end
      end else begin
        last_grant_d = last_grant_q;
      end
    end
  end

  // Bookkeeping registers; requester 0 wins first after reset.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      grant_q      <= '0;
      last_grant_q <= GW'(NUM_REQ - 1);
      beat_cnt_q   <= {LEN_W{1'b0}};
      len_err_q    <= 1'b0;
    end else begin
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      beat_cnt_q   <= beat_cnt_d;
      len_err_q    <= len_err_d;
    end
  end

  // Outputs: forward the owner's request and route the response back to it.
  always_comb begin
    busy          = 1'b0;
    oreq_valid    = 1'b0;
    oreq_is_write = 1'b0;
    oreq_addr     = 32'h0000_0000;
    oreq_len      = {LEN_W{1'b0}};
    oreq_strobe   = 4'h0;
    oreq_data     = 32'h0000_0000;
    iresp_ready   = {NUM_REQ{1'b0}};
    iresp_last    = {NUM_REQ{1'b0}};
    case (state_q)
      ST_BUSY: begin
        busy                 = 1'b1;
        oreq_valid           = cur_valid_s;
        oreq_is_write        = ireq_is_write[grant_q];
        oreq_addr            = ireq_addr[grant_q];
        oreq_len             = ireq_len[grant_q];
        oreq_strobe          = ireq_strobe[grant_q];
        oreq_data            = ireq_data[grant_q];
        iresp_ready[grant_q] = oresp_ready;
        iresp_last[grant_q]  = oresp_last;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  assign iresp_data = oresp_data;
  assign grant_idx  = grant_q;
  assign len_err    = len_err_q;

endmodule

// File: tb/tb_cbus_rr_arbiter.sv
// Bench for cbus_rr_arbiter (NUM_REQ=4): directed bursts, a transaction-level
// reference model compared every cycle, plus hand-computed literal checks.
module tb_cbus_rr_arbiter;
  localparam int NR = 4;
  localparam int LW = 4;

  logic                 clk;
  logic                 resetn;
  logic [NR-1:0]        ireq_valid;
  logic [NR-1:0]        ireq_is_write;
  logic [NR-1:0][31:0]  ireq_addr;
  logic [NR-1:0][LW-1:0] ireq_len;
  logic [NR-1:0][3:0]   ireq_strobe;
  logic [NR-1:0][31:0]  ireq_data;
  logic [NR-1:0]        iresp_ready;
  logic [NR-1:0]        iresp_last;
  logic [31:0]          iresp_data;
  logic                 oreq_valid;
  logic                 oreq_is_write;
  logic [31:0]          oreq_addr;
  logic [LW-1:0]        oreq_len;
  logic [3:0]           oreq_strobe;
  logic [31:0]          oreq_data;
  logic                 oresp_ready;
  logic                 oresp_last;
  logic [31:0]          oresp_data;
  logic [1:0]           grant_idx;
  logic                 busy;
  logic                 len_err;

  cbus_rr_arbiter #(.NUM_REQ(NR), .LEN_W(LW)) dut (
    .clk(clk), .resetn(resetn),
    .ireq_valid(ireq_valid), .ireq_is_write(ireq_is_write),
    .ireq_addr(ireq_addr), .ireq_len(ireq_len),
    .ireq_strobe(ireq_strobe), .ireq_data(ireq_data),
    .iresp_ready(iresp_ready), .iresp_last(iresp_last), .iresp_data(iresp_data),
    .oreq_valid(oreq_valid), .oreq_is_write(oreq_is_write),
    .oreq_addr(oreq_addr), .oreq_len(oreq_len),
    .oreq_strobe(oreq_strobe), .oreq_data(oreq_data),
    .oresp_ready(oresp_ready), .oresp_last(oresp_last), .oresp_data(oresp_data),
    .grant_idx(grant_idx), .busy(busy), .len_err(len_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (transaction level) ----------------
  int m_owner;   // -1 when nobody owns the bus
  int m_grant;
  int m_last;
  int m_beats;
  bit m_err;

  function automatic int rr_pick(input int last, input logic [NR-1:0] v);
    for (int k = 1; k <= NR; k++) begin
      if (v[(last + k) % NR]) return (last + k) % NR;
    end
    return -1;
  endfunction

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_owner <= -1;
      m_grant <= 0;
      m_last  <= NR - 1;
      m_beats <= 0;
      m_err   <= 1'b0;
    end else if (m_owner < 0) begin
      if (rr_pick(m_last, ireq_valid) >= 0) begin
        m_owner <= rr_pick(m_last, ireq_valid);
        m_grant <= rr_pick(m_last, ireq_valid);
        m_beats <= 0;
      end
    end else if (oresp_ready) begin
      if (ireq_valid[m_owner]) m_beats <= (m_beats + 1) % 16;
      if (oresp_last) begin
        if (m_beats != int'(ireq_len[m_owner])) m_err <= 1'b1;
        m_last  <= m_owner;
        m_owner <= -1;
      end
    end
  end

  // ---------------- per-cycle compare against the model ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", busy, m_owner >= 0);
      chk("grant_idx", grant_idx, m_grant);
      chk("len_err", len_err, m_err);
      chk("iresp_data", iresp_data, oresp_data);
      if (m_owner >= 0) begin
        chk("oreq_valid", oreq_valid, ireq_valid[m_owner]);
        chk("oreq_is_write", oreq_is_write, ireq_is_write[m_owner]);
        chk("oreq_addr", oreq_addr, ireq_addr[m_owner]);
        chk("oreq_len", oreq_len, ireq_len[m_owner]);
        chk("oreq_strobe", oreq_strobe, ireq_strobe[m_owner]);
        chk("oreq_data", oreq_data, ireq_data[m_owner]);
        chk("iresp_ready", iresp_ready, oresp_ready ? (4'b0001 << m_owner) : 4'b0000);
        chk("iresp_last", iresp_last, oresp_last ? (4'b0001 << m_owner) : 4'b0000);
      end else begin
        chk("idle_oreq", {oreq_valid, oreq_is_write, oreq_addr, oreq_len, oreq_strobe}, 42'd0);
        chk("idle_oreq_data", oreq_data, 32'h0);
        chk("idle_iresp", {iresp_ready, iresp_last}, 8'h00);
      end
    end
  end

  // ---------------- observation logs for literal checks ----------------
  logic        prev_busy = 1'b0;
  int          ir0_cnt = 0;
  int          glog[$];
  logic [31:0] dlog[$];

  always @(negedge clk) begin
    prev_busy <= busy;
    if (busy && !prev_busy) glog.push_back(int'(grant_idx));
    if (iresp_ready[0]) ir0_cnt <= ir0_cnt + 1;
    if (busy && oresp_ready) dlog.push_back(oreq_data);
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic w, input logic [31:0] a,
                         input logic [LW-1:0] l, input logic [3:0] s, input logic [31:0] d);
    ireq_valid[i]    = 1'b1;
    ireq_is_write[i] = w;
    ireq_addr[i]     = a;
    ireq_len[i]      = l;
    ireq_strobe[i]   = s;
    ireq_data[i]     = d;
  endtask

  task automatic wait_busy();
    for (int w = 0; w < 20 && !busy; w++) tick();
    chk("grant_wait", busy, 1'b1);
  endtask

  task automatic serve_burst(input int nbeats, input int last_on, input logic [31:0] base);
    wait_busy();
    for (int b = 1; b <= nbeats; b++) begin
      oresp_ready = 1'b1;
      oresp_last  = (b == last_on);
      oresp_data  = base + 32'(b - 1);
      tick();
    end
    oresp_ready = 1'b0;
    oresp_last  = 1'b0;
  endtask

  task automatic do_reset();
    oresp_ready = 1'b0;
    oresp_last  = 1'b0;
    resetn = 1'b0;
    tick();
    tick();
    resetn = 1'b1;
  endtask

  int base_i;
  int gl_base;

  initial begin
    resetn        = 1'b1;
    ireq_valid    = '0;
    ireq_is_write = '0;
    ireq_addr     = '0;
    ireq_len      = '0;
    ireq_strobe   = '0;
    ireq_data     = '0;
    oresp_ready   = 1'b0;
    oresp_last    = 1'b0;
    oresp_data    = 32'h0;
    #2;
    resetn = 1'b0;
    chk_en = 1'b1;
    tick();
    tick();
    resetn = 1'b1;

    // 1: requester 0 reads alone, len 3, memory returns A0..A3
    base_i = ir0_cnt;
    set_req(0, 1'b0, 32'h0000_1000, 4'd3, 4'h0, 32'h0);
    tick();
    chk("t1_busy_t1", busy, 1'b1);
    chk("t1_addr_t1", oreq_addr, 32'h0000_1000);
    serve_burst(4, 4, 32'h0000_00A0);
    ireq_valid[0] = 1'b0;
    tick();
    chk("t1_busy_after", busy, 1'b0);
    chk("t1_ready0_pulses", ir0_cnt - base_i, 4);
    chk("t1_len_err", len_err, 1'b0);

    // 2: both request from reset, grants alternate with one bubble
    do_reset();
    gl_base = glog.size();
    set_req(0, 1'b0, 32'h0000_1100, 4'd1, 4'h0, 32'h0);
    set_req(1, 1'b0, 32'h0000_2200, 4'd1, 4'h0, 32'h0);
    for (int n = 0; n < 4; n++) begin
      serve_burst(2, 2, 32'h0000_0010);
      chk("t2_bubble", busy, 1'b0);
    end
    ireq_valid = '0;
    tick();
    chk("t2_nlog", glog.size() - gl_base, 4);
    if (glog.size() - gl_base >= 4) begin
      chk("t2_g0", glog[gl_base],     0);
      chk("t2_g1", glog[gl_base + 1], 1);
      chk("t2_g2", glog[gl_base + 2], 0);
      chk("t2_g3", glog[gl_base + 3], 1);
    end

    // 3: requesters 1 and 3 request continuously
    do_reset();
    gl_base = glog.size();
    set_req(1, 1'b0, 32'h0000_3100, 4'd0, 4'h0, 32'h0);
    set_req(3, 1'b0, 32'h0000_3300, 4'd0, 4'h0, 32'h0);
    for (int n = 0; n < 4; n++) serve_burst(1, 1, 32'h0000_0030);
    ireq_valid = '0;
    tick();
    chk("t3_nlog", glog.size() - gl_base, 4);
    if (glog.size() - gl_base >= 4) begin
      chk("t3_g0", glog[gl_base],     1);
      chk("t3_g1", glog[gl_base + 1], 3);
      chk("t3_g2", glog[gl_base + 2], 1);
      chk("t3_g3", glog[gl_base + 3], 3);
    end
    for (int n = gl_base; n < glog.size(); n++)
      chk("t3_not_0_or_2", (glog[n] == 0) || (glog[n] == 2), 1'b0);

    // 4: requester 1 writes two beats; requester 0 waits meanwhile
    set_req(1, 1'b1, 32'h0000_2000, 4'd1, 4'hF, 32'hDEAD_BEEF);
    base_i = ir0_cnt;
    gl_base = dlog.size();
    wait_busy();
    chk("t4_grant", grant_idx, 2'd1);
    set_req(0, 1'b0, 32'h0000_3000, 4'd0, 4'h0, 32'h0);
    oresp_ready = 1'b1;
    oresp_last  = 1'b0;
    tick();
    ireq_data[1] = 32'h1234_5678;
    oresp_last   = 1'b1;
    tick();
    oresp_ready   = 1'b0;
    oresp_last    = 1'b0;
    ireq_valid[1] = 1'b0;
    chk("t4_ready0_quiet", ir0_cnt - base_i, 0);
    chk("t4_ndata", dlog.size() - gl_base, 2);
    if (dlog.size() - gl_base >= 2) begin
      chk("t4_data0", dlog[gl_base],     32'hDEAD_BEEF);
      chk("t4_data1", dlog[gl_base + 1], 32'h1234_5678);
    end
    serve_burst(1, 1, 32'h0000_00B0);
    ireq_valid[0] = 1'b0;
    tick();

    // 5: len 3 but last on beat 2 -> sticky error
    set_req(2, 1'b0, 32'h0000_4000, 4'd3, 4'h0, 32'h0);
    serve_burst(2, 2, 32'h0000_00C0);
    ireq_valid[2] = 1'b0;
    tick();
    chk("t5_err_set", len_err, 1'b1);
    set_req(3, 1'b0, 32'h0000_4400, 4'd0, 4'h0, 32'h0);
    serve_burst(1, 1, 32'h0000_00D0);
    ireq_valid[3] = 1'b0;
    tick();
    chk("t5_err_sticky", len_err, 1'b1);

    // 6: reset during beat 2 of a len-7 burst by requester 1
    do_reset();
    set_req(1, 1'b0, 32'h0000_5000, 4'd7, 4'h0, 32'h0);
    wait_busy();
    oresp_ready = 1'b1;
    oresp_last  = 1'b0;
    oresp_data  = 32'h0000_00E0;
    tick();
    oresp_data = 32'h0000_00E1;
    #2;
    resetn = 1'b0;
    #1;
    chk("t6_busy_abort", busy, 1'b0);
    chk("t6_ready_abort", iresp_ready, 4'b0000);
    chk("t6_oreq_valid_abort", oreq_valid, 1'b0);
    oresp_ready = 1'b0;
    tick();
    tick();
    resetn = 1'b1;
    set_req(0, 1'b0, 32'h0000_6000, 4'd0, 4'h0, 32'h0);
    tick();
    chk("t6_busy_restart", busy, 1'b1);
    chk("t6_grant_restart", grant_idx, 2'd0);
    serve_burst(1, 1, 32'h0000_00F0);
    ireq_valid = '0;
    tick();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
